// File: rtl/kbd_cursor_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// kbd_cursor_ctrl : Wishbone PS/2 scan-code FIFO with auto-moving cursor regs
// Rev 1.0
// ----------------------------------------------------------------------------
module kbd_cursor_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int ROWS       = 32,
  parameter int COLS       = 80,
  parameter int TIMEOUT    = 50000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic        irq_o,
  output logic [11:0] pointer_row_o,
  output logic [11:0] pointer_col_o
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [11:0]    ROW_MAX  = 12'(ROWS - 1);
  localparam logic [11:0]    COL_MAX  = 12'(COLS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_PAR  = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  logic           ps2c_s1_q, ps2c_s2_q, ps2c_prev_q, ps2d_s1_q, ps2d_s2_q;
  logic           fall, bit_in;
  logic [1:0]     state_q, state_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           done_q, done_d, good_q, good_d;

  logic           ack_q, err_q;
  logic [31:0]    dat_q, rdata;
  logic [2:0]     ctrl_q;
  logic [11:0]    row_q, row_d, col_q, col_d;
  logic           ext_q, ext_d, brk_q, brk_d;
  logic           ovf_q, ferr_q, irq_q;
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           acc, bad, wr;
  logic [3:0]     idx;
  logic           empty, full, pop, push_req, push;
  logic           unused_ok;

  assign unused_ok = ^{wb_sel_i, wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i[31:12]};

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      {ps2c_s1_q, ps2c_s2_q, ps2c_prev_q, ps2d_s1_q, ps2d_s2_q} <= '1;
    end else begin
      ps2c_s1_q   <= ps2_clk_i;
      ps2c_s2_q   <= ps2c_s1_q;
      ps2c_prev_q <= ps2c_s2_q;
      ps2d_s1_q   <= ps2_data_i;
      ps2d_s2_q   <= ps2d_s1_q;
    end
  end

  assign fall   = ps2c_prev_q & ~ps2c_s2_q;
  assign bit_in = ps2d_s2_q;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    wd_d     = '0;
    done_d   = 1'b0;
    good_d   = 1'b0;
    if (!ctrl_q[0]) begin
      state_d = S_IDLE;
    end else if (fall) begin
      case (state_q)
        S_IDLE: if (!bit_in) begin
          state_d  = S_DATA;
          bitcnt_d = '0;
          par_d    = 1'b0;
        end
        S_DATA: begin
          shift_d  = {bit_in, shift_q[7:1]};
          par_d    = par_q ^ bit_in;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_PAR;
        end
        S_PAR: begin
          par_d   = par_q ^ bit_in;
          state_d = S_STOP;
        end
        default: begin
          done_d  = 1'b1;
          good_d  = bit_in & par_q;
          state_d = S_IDLE;
        end
      endcase
    end else if (state_q != S_IDLE) begin
      // Stalled frame: abandon silently once the line has been quiet too long
      if (wd_q == WD_LAST) state_d = S_IDLE;
      else wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      wd_q     <= '0;
      done_q   <= 1'b0;
      good_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      wd_q     <= wd_d;
      done_q   <= done_d;
      good_q   <= good_d;
    end
  end

  assign idx      = wb_adr_i[5:2];
  assign bad      = idx > 4'd4;
  assign acc      = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
  assign wr       = acc & wb_we_i & ~bad;
  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign pop      = acc & ~wb_we_i & (idx == 4'd0) & ~empty;
  assign push_req = done_q & good_q;
  assign push     = push_req & (~full | pop);

  always_comb begin
    case (idx)
      4'd0:    rdata = empty ? 32'h0 : {23'b0, 1'b1, mem_q[rd_ptr_q]};
      4'd1:    rdata = {20'b0, row_q};
      4'd2:    rdata = {20'b0, col_q};
      4'd3:    rdata = {16'b0, 8'(count_q), 4'b0, ferr_q, ovf_q, full, empty};
      4'd4:    rdata = {29'b0, ctrl_q};
      default: rdata = 32'h0;
    endcase
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    ext_d = ext_q;
    brk_d = brk_q;
    if (push_req && ctrl_q[2]) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (ext_q && !brk_q) begin
          case (shift_q)
            8'h75: if (row_q != 12'd0)  row_d = row_q - 12'd1;
            8'h72: if (row_q < ROW_MAX) row_d = row_q + 12'd1;
            8'h6B: if (col_q != 12'd0)  col_d = col_q - 12'd1;
            8'h74: if (col_q < COL_MAX) col_d = col_q + 12'd1;
            default: ;
          endcase
        end
      end
    end
    // A bus write overrides an auto-cursor move in the same cycle
    if (wr && idx == 4'd1) row_d = (wb_dat_i[11:0] > ROW_MAX) ? ROW_MAX : wb_dat_i[11:0];
    if (wr && idx == 4'd2) col_d = (wb_dat_i[11:0] > COL_MAX) ? COL_MAX : wb_dat_i[11:0];
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_q    <= '0;
      ctrl_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
      irq_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ack_q <= acc & ~bad;
      err_q <= acc & bad;
      if (acc) dat_q <= rdata;
      if (wr && idx == 4'd4) ctrl_q <= wb_dat_i[2:0];
      row_q <= row_d;
      col_q <= col_d;
      ext_q <= ext_d;
      brk_q <= brk_d;
      ovf_q  <= (ovf_q  & ~(wr && idx == 4'd3 && wb_dat_i[2])) | (push_req & full & ~pop);
      ferr_q <= (ferr_q & ~(wr && idx == 4'd3 && wb_dat_i[3])) | (done_q & ~good_q);
      irq_q  <= ctrl_q[1] & ~empty;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign wb_ack_o      = ack_q;
  assign wb_err_o      = err_q;
  assign wb_dat_o      = dat_q;
  assign irq_o         = irq_q;
  assign pointer_row_o = row_q;
  assign pointer_col_o = col_q;

endmodule
`default_nettype wire

// File: tb/tb_kbd_cursor_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_kbd_cursor_ctrl : scoreboard bench for the PS/2 keyboard/cursor block
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_kbd_cursor_ctrl;
  localparam int TMO = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, wdat = '0;
  logic [31:0] rdat;
  logic        ack, err, irq;
  logic        ps2c = 1'b1, ps2d = 1'b1;
  logic [11:0] prow, pcol;

  typedef struct packed {
    logic        err;
    logic        chk;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  kbd_cursor_ctrl #(.FIFO_DEPTH(8), .ROWS(32), .COLS(80), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(4'hF),
    .wb_dat_o(rdat), .wb_ack_o(ack), .wb_err_o(err),
    .ps2_clk_i(ps2c), .ps2_data_i(ps2d),
    .irq_o(irq), .pointer_row_o(prow), .pointer_col_o(pcol)
  );

  always #5 clk = ~clk;

  // Monitor: every bus termination is matched against the oldest expectation
  always @(negedge clk) begin
    if (ack || err) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL bus_unexpected: ack=%0b err=%0b with no access pending", ack, err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({ack, err} != {~e.err, e.err} || (e.chk && rdat != e.d)) begin
          n_bad++;
          $display("FAIL bus_read: got ack=%0b err=%0b dat=0x%08h, expected err=%0b dat=0x%08h",
                   ack, err, rdat, e.err, e.d);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic bus(input logic w, input logic [3:0] i, input logic [31:0] d,
                     input logic e_err, input logic e_chk, input logic [31:0] e_d);
    exp_t e;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = {26'b0, i, 2'b00}; wdat = d;
    e.err = e_err; e.chk = e_chk; e.d = e_d;
    exp_q.push_back(e);
    @(posedge clk); #1;
    check("bus_latency", {31'b0, ack | err}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] i, input logic [31:0] e_d);
    bus(1'b0, i, 32'h0, 1'b0, 1'b1, e_d);
  endtask

  task automatic wr(input logic [3:0] i, input logic [31:0] d);
    bus(1'b1, i, d, 1'b0, 1'b0, 32'h0);
  endtask

  // Sends the first nbits of a frame (start, 8 data LSB first, parity, stop)
  task automatic send(input logic [7:0] code, input logic bad_par, input logic bad_stop, input int nbits);
    logic [10:0] fb;
    fb = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
    for (int b = 0; b < nbits; b++) begin
      @(negedge clk); ps2d = fb[b];
      repeat (3) @(negedge clk);
      ps2c = 1'b0;
      repeat (6) @(negedge clk);
      ps2c = 1'b1;
      repeat (3) @(negedge clk);
    end
    ps2d = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] code);
    send(code, 1'b0, 1'b0, 11);
  endtask

  logic [7:0] seq_a [7] = '{8'hE0, 8'h74, 8'hE0, 8'h72, 8'hE0, 8'hF0, 8'h72};
  logic [7:0] seq_b [6] = '{8'hE0, 8'h6B, 8'hE0, 8'h75, 8'hE0, 8'h75};

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (4) @(negedge clk);
    #1;
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_dat", rdat, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_row", {20'b0, prow}, 32'd0);
    check("rst_col", {20'b0, pcol}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    rd(4'd0, 32'h0); rd(4'd1, 32'h0); rd(4'd2, 32'h0);
    rd(4'd3, 32'h0001); rd(4'd4, 32'h0);

    // Single frame with interrupt
    wr(4'd4, 32'h3);
    frame(8'h1C);
    check("irq_rise", {31'b0, irq}, 32'd1);
    rd(4'd3, 32'h0100);
    rd(4'd0, 32'h11C);
    rd(4'd0, 32'h000);
    repeat (3) @(negedge clk);
    check("irq_fall", {31'b0, irq}, 32'd0);

    // Overflow
    wr(4'd4, 32'h1);
    for (int k = 0; k < 9; k++) frame(8'h10 + 8'(k));
    rd(4'd3, 32'h0806);
    for (int k = 0; k < 8; k++) rd(4'd0, 32'h110 + 32'(k));
    rd(4'd3, 32'h0005);
    wr(4'd3, 32'h4);
    rd(4'd3, 32'h0001);

    // Framing errors and watchdog
    send(8'h33, 1'b1, 1'b0, 11);
    send(8'h44, 1'b0, 1'b1, 11);
    rd(4'd3, 32'h0009);
    send(8'hA5, 1'b0, 1'b0, 4);
    repeat (TMO + 1) @(negedge clk);
    frame(8'h5A);
    rd(4'd0, 32'h15A);
    wr(4'd3, 32'h8);
    rd(4'd3, 32'h0001);

    // Auto-cursor
    wr(4'd4, 32'h5);
    wr(4'd1, 32'h0);
    wr(4'd2, 32'd79);
    for (int k = 0; k < 7; k++) frame(seq_a[k]);
    rd(4'd2, 32'd79);
    rd(4'd1, 32'd1);
    check("ptr_row", {20'b0, prow}, 32'd1);
    check("irq_masked", {31'b0, irq}, 32'd0);
    rd(4'd3, 32'h0700);
    for (int k = 0; k < 7; k++) rd(4'd0, {23'b0, 1'b1, seq_a[k]});
    for (int k = 0; k < 6; k++) frame(seq_b[k]);
    rd(4'd2, 32'd78);
    rd(4'd1, 32'd0);
    check("ptr_col", {20'b0, pcol}, 32'd78);
    for (int k = 0; k < 6; k++) rd(4'd0, {23'b0, 1'b1, seq_b[k]});

    // Address error and clamping
    bus(1'b0, 4'd7, 32'h0, 1'b1, 1'b0, 32'h0);
    wr(4'd1, 32'hFFF);
    rd(4'd1, 32'd31);
    wr(4'd2, 32'd80);
    rd(4'd2, 32'd79);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
